imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, instruction words stored (power of two).
REQ-002 SHALL have parameter WAIT_CYC, default 1, extra cycles between request accept and response (0..7).
REQ-003 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fetch_req  in  1  fetch request, held high by initiator until fetch_vld.
REQ-006 SHALL have port fetch_addr  in  32  word index (PC increments by 1 per instruction), stable while fetch_req high.
REQ-007 SHALL have port fetch_rdy  out  1  high only in IDLE, i.e. a request is accepted this cycle.
REQ-008 SHALL have port fetch_vld  out  1  one-cycle response strobe.
REQ-009 SHALL have port fetch_data  out  32  instruction word, valid when fetch_vld high.
REQ-010 SHALL have port fetch_err  out  1  address out of range (or parity fail), qualified by fetch_vld.
REQ-011 SHALL have ports ld_we  in  1, ld_addr  in  log2(DEPTH), ld_data  in  32: program-loader write port.

Function
REQ-012 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; with WAIT_CYC=0, IDLE -> RESP directly.
REQ-013 SHALL accept a request in IDLE when fetch_req=1, capturing fetch_addr in that cycle.
REQ-014 SHALL stay in WAIT for exactly WAIT_CYC cycles via down-counter loaded with WAIT_CYC-1 on accept.
REQ-015 SHALL assert fetch_vld for exactly one cycle in RESP; request-accept-to-fetch_vld latency = WAIT_CYC+1 cycles.
REQ-016 SHALL read the array on the cycle entering RESP; fetch_data/fetch_err hold last values while fetch_vld low.
REQ-017 SHALL, for captured address >= DEPTH, return fetch_data=32'h00000013 (NOP) with fetch_err=1, array not read.
REQ-018 SHALL write ld_data to ld_addr on any cycle ld_we=1, in every FSM state.
REQ-019 SHALL, for loader write and read to the same word in the same cycle, return the old word (read-before-write).
REQ-020 SHALL ignore fetch_req in WAIT and RESP; back-to-back requests yield one response every WAIT_CYC+2 cycles.
REQ-021 SHALL ignore changes of fetch_addr after accept (captured value used).

Reset
REQ-022 SHALL, on rst_n low, asynchronously force state=IDLE, counter=0, fetch_vld=0, fetch_data=0, fetch_err=0; fetch_rdy=1 after release.
REQ-023 SHALL abort an in-flight fetch on reset with no response afterwards.
REQ-024 SHALL NOT clear array contents on reset.

Configuration
REQ-025 SHALL, with IMEM_PARITY_EN defined, store an even-parity bit per word, check it on read, set fetch_err=1 on mismatch (data returned unmodified), and add input ld_par_flip (1) inverting the stored parity bit on write.
REQ-026 SHALL, without IMEM_PARITY_EN, have no parity storage, no ld_par_flip port, fetch_err set only by REQ-017.

Structure
REQ-027 SHALL take the FSM state enum, NOP constant 32'h00000013 and default DEPTH from shared package rv32_imem_pkg.
REQ-028 SHALL place storage in sub-module imem_array (1 write, 1 synchronous read port, read-before-write, optional parity column).

Verification
REQ-029 SHALL cover: load word 5 = 32'h0015_8593, reset release, fetch_addr=5, WAIT_CYC=1 -> fetch_vld two cycles after accept, data 32'h00158593, err 0.
REQ-030 SHALL cover: fetch_addr=1024 (DEPTH 1024) -> fetch_vld with data 32'h00000013, err 1.
REQ-031 SHALL cover: ld_we to word 7 (new 32'hDEAD_BEEF, old 0) on the cycle entering RESP for addr 7 -> data 0; refetch -> 32'hDEADBEEF.
REQ-032 SHALL cover: fetch_req held high continuously, WAIT_CYC=0, addrs 0,1,2 -> vld every 2 cycles, fetch_rdy low in RESP.
REQ-033 SHALL cover: rst_n pulsed low in WAIT -> fetch_vld never rises for that request, outputs 0, next request served normally.
REQ-034 SHALL cover (IMEM_PARITY_EN): write word 3 with ld_par_flip=1, fetch 3 -> fetch_err 1, data equals written word.

Source files
------------

// File: rtl/rv32_imem_pkg.sv
// rv32_imem_pkg: shared FSM state encoding, NOP word and default depth for imem_responder.
package rv32_imem_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} imem_state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int IMEM_DEPTH = 1024;
  function automatic logic out_of_range(input logic [31:0] a, input int depth);
    return a >= 32'(depth);
  endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: instruction storage, one write port, one registered read-before-write read port.
// IMEM_PARITY_EN adds an even-parity column checked on every read.
module imem_array #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
`ifdef IMEM_PARITY_EN
  input  logic          par_flip,
  output logic          par_err,
`endif
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // contents survive reset; only the read register is cleared
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
`ifdef IMEM_PARITY_EN
  logic par [DEPTH];
  always_ff @(posedge clk)
    if (we) par[waddr] <= ^wdata ^ par_flip;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par_err <= 1'b0;
    else if (re) par_err <= (^mem[raddr]) != par[raddr];
`endif
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction fetch responder with program-loader write port.
// IMEM_PARITY_EN enables per-word parity and the ld_par_flip port.
module imem_responder
  import rv32_imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int WAIT_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_req,
  input  logic [31:0]              fetch_addr,
  output logic                     fetch_rdy,
  output logic                     fetch_vld,
  output logic [31:0]              fetch_data,
  output logic                     fetch_err,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
`ifdef IMEM_PARITY_EN
  input  logic                     ld_par_flip,
`endif
  input  logic [31:0]              ld_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = 3'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);
  imem_state_t state;
  logic [2:0] cnt;
  logic [AW-1:0] addr_q, raddr;
  logic oor_q, oor_rsp, oor_now, accept, go_resp;
  logic [31:0] rdata;
  assign fetch_rdy = state == ST_IDLE;
  assign fetch_vld = state == ST_RESP;
  assign accept = fetch_rdy & fetch_req;
  assign go_resp = (accept && WAIT_CYC == 0) || (state == ST_WAIT && cnt == 3'd0);
  // with no wait cycles the read happens in the accept cycle, straight off the port
  assign raddr = fetch_rdy ? fetch_addr[AW-1:0] : addr_q;
  assign oor_now = fetch_rdy ? out_of_range(fetch_addr, DEPTH) : oor_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      addr_q <= '0;
      oor_q <= 1'b0;
      oor_rsp <= 1'b0;
    end else begin
      state <= go_resp ? ST_RESP : accept ? ST_WAIT : state == ST_RESP ? ST_IDLE : state;
      if (go_resp) oor_rsp <= oor_now;
      if (accept) begin
        addr_q <= fetch_addr[AW-1:0];
        oor_q <= out_of_range(fetch_addr, DEPTH);
        cnt <= CNT_INIT;
      end else if (state == ST_WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
    end
  assign fetch_data = oor_rsp ? NOP : rdata;
`ifdef IMEM_PARITY_EN
  logic par_err;
  assign fetch_err = oor_rsp | par_err;
`else
  assign fetch_err = oor_rsp;
`endif
  imem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .rst_n(rst_n),
    .we(ld_we),
    .waddr(ld_addr),
    .wdata(ld_data),
`ifdef IMEM_PARITY_EN
    .par_flip(ld_par_flip),
    .par_err(par_err),
`endif
    .re(go_resp & ~oor_now),
    .raddr(raddr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: two responders (WAIT_CYC 1 and 0) sharing one loader, checked against a
// timestamp-based fetch model every cycle plus directed literal checks.
module tb_imem_responder;
  localparam int W0 = 1;
  localparam int W1 = 0;
`ifdef IMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, ld_we = 1'b0, ld_par_flip = 1'b0;
  logic [9:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic req [2];
  logic [31:0] addr [2];
  logic rdy [2], vld [2], err [2];
  logic [31:0] data [2];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  imem_responder #(.DEPTH(1024), .WAIT_CYC(W0)) dut0 (
    .clk(clk), .rst_n(rst_n), .fetch_req(req[0]), .fetch_addr(addr[0]),
    .fetch_rdy(rdy[0]), .fetch_vld(vld[0]), .fetch_data(data[0]), .fetch_err(err[0]),
    .ld_we(ld_we), .ld_addr(ld_addr),
`ifdef IMEM_PARITY_EN
    .ld_par_flip(ld_par_flip),
`endif
    .ld_data(ld_data));
  imem_responder #(.DEPTH(1024), .WAIT_CYC(W1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fetch_req(req[1]), .fetch_addr(addr[1]),
    .fetch_rdy(rdy[1]), .fetch_vld(vld[1]), .fetch_data(data[1]), .fetch_err(err[1]),
    .ld_we(ld_we), .ld_addr(ld_addr),
`ifdef IMEM_PARITY_EN
    .ld_par_flip(ld_par_flip),
`endif
    .ld_data(ld_data));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each lane records when its response is due and when it can accept again.
  logic [31:0] mm [1024];
  bit mf [1024];
  int cyc = 0;
  int rc [2] = '{-1, -1};
  int nf [2] = '{0, 0};
  logic [31:0] ma [2] = '{0, 0};
  logic [31:0] ed [2] = '{0, 0};
  logic ee [2] = '{0, 0};
  initial begin
    foreach (mm[i]) begin mm[i] = '0; mf[i] = 1'b0; end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++)
        if (!rst_n) begin
          nf[i] = 0; rc[i] = -1; ed[i] = '0; ee[i] = 1'b0;
        end else begin
          if (cyc >= nf[i] && req[i]) begin
            rc[i] = cyc + (i == 0 ? W0 : W1) + 1;
            nf[i] = rc[i] + 1;
            ma[i] = addr[i];
          end
          if (cyc + 1 == rc[i]) begin
            ee[i] = ma[i] >= 1024 || (PAR && mf[ma[i][9:0]]);
            ed[i] = ma[i] >= 1024 ? 32'h0000_0013 : mm[ma[i][9:0]];
          end
        end
      if (rst_n && ld_we) begin
        mm[ld_addr] = ld_data;
        mf[ld_addr] = PAR && ld_par_flip;
      end
      cyc++;
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_rdy%0d", i), 32'(rdy[i]), 32'(cyc >= nf[i]));
      chk($sformatf("model_vld%0d", i), 32'(vld[i]), 32'(cyc == rc[i]));
      chk($sformatf("model_data%0d", i), data[i], ed[i]);
      chk($sformatf("model_err%0d", i), 32'(err[i]), 32'(ee[i]));
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick;
    ld_we = 1'b0;
  endtask

  task automatic fetch(input int l, input logic [31:0] a, output int lat, output logic [31:0] d, output logic e);
    req[l] = 1'b1; addr[l] = a; lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (vld[l]) break;
    end
    if (!vld[l]) begin
      n_chk++; n_fail++;
      $display("FAIL fetch_timeout lane %0d addr %h: no fetch_vld within 20 cycles", l, a);
    end
    d = data[l]; e = err[l];
    tick;
    req[l] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n;
    logic [31:0] d;
    logic e;
    req[0] = 1'b0; req[1] = 1'b0; addr[0] = '0; addr[1] = '0;
    repeat (2) tick;
    @(negedge clk);
    chk("rst_data", data[0], 32'h0);
    chk("rst_vld", 32'(vld[0]), 32'h0);
    chk("rst_err", 32'(err[0]), 32'h0);
    chk("rst_rdy", 32'(rdy[0]), 32'h1);
    tick;
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++)
      load(10'(a), a == 5 ? 32'h0015_8593 : a == 7 ? 32'h0 : 32'hA000_0000 | 32'(a));
    load(10'd1023, 32'hA000_03FF);
    fetch(0, 32'd5, lat, d, e);
    chk("w5_lat", 32'(lat), 32'd3);
    chk("w5_data", d, 32'h0015_8593);
    chk("w5_err", 32'(e), 32'h0);
    fetch(0, 32'd1024, lat, d, e);
    chk("oor_data", d, 32'h0000_0013);
    chk("oor_err", 32'(e), 32'h1);
    fetch(1, 32'hFFFF_FFFF, lat, d, e);
    chk("oor_max_lat", 32'(lat), 32'd2);
    chk("oor_max_data", d, 32'h0000_0013);
    chk("oor_max_err", 32'(e), 32'h1);
    fetch(1, 32'd1023, lat, d, e);
    chk("top_data", d, 32'hA000_03FF);
    chk("top_err", 32'(e), 32'h0);
    req[0] = 1'b1; addr[0] = 32'd7;
    @(negedge clk);
    tick;
    ld_we = 1'b1; ld_addr = 10'd7; ld_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rbw_wait_vld", 32'(vld[0]), 32'h0);
    tick;
    ld_we = 1'b0;
    @(negedge clk);
    chk("rbw_vld", 32'(vld[0]), 32'h1);
    chk("rbw_old", data[0], 32'h0);
    tick;
    req[0] = 1'b0;
    fetch(0, 32'd7, lat, d, e);
    chk("rbw_new", d, 32'hDEAD_BEEF);
    req[0] = 1'b1; addr[0] = 32'd9;
    @(negedge clk);
    tick;
    addr[0] = 32'd3;
    @(negedge clk);
    tick;
    @(negedge clk);
    chk("cap_vld", 32'(vld[0]), 32'h1);
    chk("cap_data", data[0], 32'hA000_0009);
    tick;
    req[0] = 1'b0;
    req[1] = 1'b1; addr[1] = 32'd0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (n < 10) begin
        @(negedge clk);
        n++;
        if (vld[1]) break;
      end
      chk($sformatf("b2b_gap%0d", k), 32'(n), 32'd2);
      chk($sformatf("b2b_data%0d", k), data[1], 32'hA000_0000 | 32'(k));
      chk($sformatf("b2b_rdy%0d", k), 32'(rdy[1]), 32'h0);
      tick;
      addr[1] = 32'(k + 1);
    end
    req[1] = 1'b0;
    req[0] = 1'b1; addr[0] = 32'd5;
    @(negedge clk);
    tick;
    rst_n = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    chk("abort_data", data[0], 32'h0);
    chk("abort_vld", 32'(vld[0]), 32'h0);
    chk("abort_err", 32'(err[0]), 32'h0);
    chk("abort_rdy", 32'(rdy[0]), 32'h1);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("abort_quiet%0d", k), 32'(vld[0]), 32'h0);
    end
    tick;
    fetch(0, 32'd6, lat, d, e);
    chk("after_rst_lat", 32'(lat), 32'd3);
    chk("after_rst_data", d, 32'hA000_0006);
`ifdef IMEM_PARITY_EN
    ld_par_flip = 1'b1;
    load(10'd3, 32'h1234_5678);
    ld_par_flip = 1'b0;
    fetch(0, 32'd3, lat, d, e);
    chk("par_data", d, 32'h1234_5678);
    chk("par_err", 32'(e), 32'h1);
    load(10'd3, 32'h1234_5678);
    fetch(0, 32'd3, lat, d, e);
    chk("par_ok_err", 32'(e), 32'h0);
`endif
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
